// File: rtl/toy_intr_pkg.sv
// Shared types and constants for the interrupt pending/dispatch controller.
// Bit indices apply to both the pending vector and the enable vector.
package toy_intr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REQ      = 2'd1,
        ST_WAIT_CLR = 2'd2
    } intr_st_e;

    localparam int CAUSE_W = 4;
    localparam int NSRC    = 6;
    localparam int NEN     = 5;

    localparam logic [CAUSE_W-1:0] CAUSE_DEBUG = 4'd15;
    localparam logic [CAUSE_W-1:0] CAUSE_MEI   = 4'd11;
    localparam logic [CAUSE_W-1:0] CAUSE_MSI   = 4'd3;
    localparam logic [CAUSE_W-1:0] CAUSE_SEI   = 4'd9;
    localparam logic [CAUSE_W-1:0] CAUSE_SSI   = 4'd1;
    localparam logic [CAUSE_W-1:0] CAUSE_STI   = 4'd5;

    localparam int IDX_SSIP  = 0;
    localparam int IDX_STIP  = 1;
    localparam int IDX_SEIP  = 2;
    localparam int IDX_MSIP  = 3;
    localparam int IDX_MEIP  = 4;
    localparam int IDX_DEBUG = 5;

    // Maps a dispatched cause code back to its pending bit, so the
    // bit to clear is always the one that was offered, not today's winner.
    function automatic logic [NSRC-1:0] cause_to_mask(input logic [CAUSE_W-1:0] code);
        logic [NSRC-1:0] m;
        m = '0;
        case (code)
            CAUSE_DEBUG: m[IDX_DEBUG] = 1'b1;
            CAUSE_MEI:   m[IDX_MEIP]  = 1'b1;
            CAUSE_MSI:   m[IDX_MSIP]  = 1'b1;
            CAUSE_SEI:   m[IDX_SEIP]  = 1'b1;
            CAUSE_SSI:   m[IDX_SSIP]  = 1'b1;
            CAUSE_STI:   m[IDX_STIP]  = 1'b1;
            default:     m = '0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/toy_intr_ctrl_if.sv
// Dispatch handshake between the interrupt controller and the core.
// master = controller side, slave = core side.
interface toy_intr_ctrl_if;
    import toy_intr_pkg::*;

    logic               intr_vld;
    logic [CAUSE_W-1:0] intr_op;
    logic               intr_rdy;
    logic               intr_clr;

    modport master (
        output intr_vld,
        output intr_op,
        input  intr_rdy,
        input  intr_clr
    );

    modport slave (
        input  intr_vld,
        input  intr_op,
        output intr_rdy,
        output intr_clr
    );

endinterface

// File: rtl/toy_intr_prio_enc.sv
// Fixed-priority picker over the eligible vector; emits the winner's cause code.
// Order is debug, meip, msip, seip, ssip, stip (ssip beats stip despite its lower index).
module toy_intr_prio_enc
    import toy_intr_pkg::*;
(
    input  logic [NSRC-1:0]    elig,
    output logic               any,
    output logic [CAUSE_W-1:0] code
);

    always_comb begin
        any  = |elig;
        code = '0;
        if (elig[IDX_DEBUG])     code = CAUSE_DEBUG;
        else if (elig[IDX_MEIP]) code = CAUSE_MEI;
        else if (elig[IDX_MSIP]) code = CAUSE_MSI;
        else if (elig[IDX_SEIP]) code = CAUSE_SEI;
        else if (elig[IDX_SSIP]) code = CAUSE_SSI;
        else if (elig[IDX_STIP]) code = CAUSE_STI;
    end

endmodule

// File: rtl/toy_intr_ctrl.sv
// Interrupt pending/dispatch controller: latches sync pulses, picks a winner,
// offers it over vld/rdy and holds off until the core re-arms with intr_clr.
//
// state       | meaning
// ST_IDLE     | no request outstanding; dispatch next eligible source
// ST_REQ      | intr_vld high with a frozen cause code, waiting for intr_rdy
// ST_WAIT_CLR | accepted; waiting for trap entry to finish (optional watchdog)
module toy_intr_ctrl
    import toy_intr_pkg::*;
#(
    parameter int CLR_TIMEOUT = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             intr_meip_sync,
    input  logic             intr_msip_sync,
    input  logic             intr_seip_sync,
    input  logic             intr_stip_sync,
    input  logic             intr_ssip_sync,
    input  logic             intr_debug_sync,
    input  logic [NEN-1:0]   intr_en,
    input  logic             glb_ie,
    toy_intr_ctrl_if.master  core_if,
    output logic [NSRC-1:0]  intr_pend,
    output logic             intr_busy,
    output logic             intr_timeout_err
);

    localparam bit WD_EN = (CLR_TIMEOUT > 0);
    localparam int CNT_W = WD_EN ? $clog2(CLR_TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] TMO_VAL = CNT_W'(CLR_TIMEOUT);

    intr_st_e           st_q, st_d;
    logic [NSRC-1:0]    pend_q, pend_d;
    logic [NSRC-1:0]    sync_vec;
    logic [NSRC-1:0]    elig;
    logic [NSRC-1:0]    clr_mask;
    logic [CAUSE_W-1:0] op_q;
    logic [CAUSE_W-1:0] win_code;
    logic               win_any;
    logic               load_op;
    logic               accept;
    logic               tmo;
    logic [CNT_W-1:0]   wd_cnt_q;

    always_comb begin
        sync_vec            = '0;
        sync_vec[IDX_SSIP]  = intr_ssip_sync;
        sync_vec[IDX_STIP]  = intr_stip_sync;
        sync_vec[IDX_SEIP]  = intr_seip_sync;
        sync_vec[IDX_MSIP]  = intr_msip_sync;
        sync_vec[IDX_MEIP]  = intr_meip_sync;
        sync_vec[IDX_DEBUG] = intr_debug_sync;
    end

    // Debug bypasses both the per-source and the global enable.
    assign elig = {pend_q[IDX_DEBUG], pend_q[NEN-1:0] & intr_en & {NEN{glb_ie}}};

    toy_intr_prio_enc u_prio_enc (
        .elig (elig),
        .any  (win_any),
        .code (win_code)
    );

    assign accept   = (st_q == ST_REQ) && core_if.intr_rdy;
    assign clr_mask = accept ? cause_to_mask(op_q) : '0;
    // A new pulse in the same cycle as the clear keeps the bit set.
    assign pend_d   = (pend_q & ~clr_mask) | sync_vec;

    always_comb begin
        st_d    = st_q;
        load_op = 1'b0;
        tmo     = 1'b0;
        case (st_q)
            ST_IDLE: begin
                if (win_any) begin
                    st_d    = ST_REQ;
                    load_op = 1'b1;
                end
            end
            ST_REQ: begin
                if (core_if.intr_rdy) st_d = ST_WAIT_CLR;
            end
            ST_WAIT_CLR: begin
                if (core_if.intr_clr) begin
                    st_d = ST_IDLE;
                end else if (WD_EN && (wd_cnt_q == TMO_VAL)) begin
                    tmo  = 1'b1;
                    st_d = ST_IDLE;
                end
            end
            default: st_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q   <= ST_IDLE;
            pend_q <= '0;
            op_q   <= '0;
        end else begin
            st_q   <= st_d;
            pend_q <= pend_d;
            if (load_op) op_q <= win_code;
        end
    end

    // Held at zero outside WAIT_CLR, so every entry starts counting from zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt_q <= '0;
        end else if (WD_EN && (st_q == ST_WAIT_CLR)) begin
            wd_cnt_q <= wd_cnt_q + CNT_W'(1);
        end else begin
            wd_cnt_q <= '0;
        end
    end

    assign core_if.intr_vld = (st_q == ST_REQ);
    assign core_if.intr_op  = op_q;
    assign intr_pend        = pend_q;
    assign intr_busy        = (st_q != ST_IDLE);
    assign intr_timeout_err = tmo;

    a_op_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (core_if.intr_vld && !core_if.intr_rdy) |=> (core_if.intr_vld && $stable(core_if.intr_op)));

    a_no_vld_after_acc: assert property (@(posedge clk) disable iff (!rst_n)
        accept |=> !core_if.intr_vld);

endmodule

// File: tb/tb_toy_intr_ctrl.sv
// Scoreboarded bench for toy_intr_ctrl: directed stimulus pushes expected cause
// codes; a negedge monitor pops and compares them on every accepted request.
module tb_toy_intr_ctrl;
    import toy_intr_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       meip = 1'b0, msip = 1'b0, seip = 1'b0, stip = 1'b0, ssip = 1'b0, dbg = 1'b0;
    logic [4:0] intr_en = '0;
    logic       glb_ie = 1'b0;
    logic [5:0] intr_pend;
    logic       intr_busy;
    logic       intr_timeout_err;

    int n_chk  = 0;
    int n_fail = 0;
    logic [3:0] exp_op_q[$];
    int exp_err_cnt = 0;

    toy_intr_ctrl_if bus ();

    toy_intr_ctrl #(.CLR_TIMEOUT(4)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .intr_meip_sync   (meip),
        .intr_msip_sync   (msip),
        .intr_seip_sync   (seip),
        .intr_stip_sync   (stip),
        .intr_ssip_sync   (ssip),
        .intr_debug_sync  (dbg),
        .intr_en          (intr_en),
        .glb_ie           (glb_ie),
        .core_if          (bus),
        .intr_pend        (intr_pend),
        .intr_busy        (intr_busy),
        .intr_timeout_err (intr_timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Vector order matches intr_pend: {debug, meip, msip, seip, stip, ssip}.
    task automatic drive_sync(input logic [5:0] v);
        dbg  = v[5];
        meip = v[4];
        msip = v[3];
        seip = v[2];
        stip = v[1];
        ssip = v[0];
    endtask

    task automatic pulse(input logic [5:0] v);
        drive_sync(v);
        tick();
        drive_sync(6'b0);
    endtask

    task automatic wait_vld();
        int n = 0;
        while (!bus.intr_vld && n < 20) begin
            tick();
            n++;
        end
        chk("vld_wait", {31'b0, bus.intr_vld}, 1);
    endtask

    task automatic serve();
        wait_vld();
        bus.intr_rdy = 1'b1;
        tick();
        bus.intr_rdy = 1'b0;
        chk("acc_vld_low", {31'b0, bus.intr_vld}, 0);
        bus.intr_clr = 1'b1;
        tick();
        bus.intr_clr = 1'b0;
        chk("clr_idle", {31'b0, intr_busy}, 0);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.intr_vld && bus.intr_rdy) begin
                if (exp_op_q.size() == 0) begin
                    chk("unexpected_dispatch", {28'b0, bus.intr_op}, 0);
                end else begin
                    chk("sb_op", {28'b0, bus.intr_op}, {28'b0, exp_op_q.pop_front()});
                end
            end
            if (intr_timeout_err) begin
                chk("tmo_expected", (exp_err_cnt > 0) ? 1 : 0, 1);
                if (exp_err_cnt > 0) exp_err_cnt--;
            end
        end
    end

    initial begin
        bus.intr_rdy = 1'b0;
        bus.intr_clr = 1'b0;
        tick();
        tick();
        chk("rst_vld",  {31'b0, bus.intr_vld}, 0);
        chk("rst_op",   {28'b0, bus.intr_op}, 0);
        chk("rst_pend", {26'b0, intr_pend}, 0);
        chk("rst_busy", {31'b0, intr_busy}, 0);
        chk("rst_err",  {31'b0, intr_timeout_err}, 0);
        rst_n = 1'b1;
        tick();

        // Basic msip dispatch with latency checks.
        intr_en = 5'b01000;
        glb_ie  = 1'b1;
        exp_op_q.push_back(CAUSE_MSI);
        pulse(6'b001000);
        chk("msip_pend_n1", {26'b0, intr_pend}, 6'b001000);
        chk("msip_vld_n1", {31'b0, bus.intr_vld}, 0);
        tick();
        chk("msip_vld_n2", {31'b0, bus.intr_vld}, 1);
        chk("msip_op_n2", {28'b0, bus.intr_op}, 3);
        bus.intr_rdy = 1'b1;
        tick();
        bus.intr_rdy = 1'b0;
        chk("msip_pend_clr", {26'b0, intr_pend}, 0);
        chk("msip_busy_wait", {31'b0, intr_busy}, 1);
        bus.intr_clr = 1'b1;
        tick();
        bus.intr_clr = 1'b0;
        chk("msip_idle", {31'b0, intr_busy}, 0);

        // Three simultaneous sources dispatch in priority order.
        intr_en = 5'b11111;
        exp_op_q.push_back(CAUSE_DEBUG);
        exp_op_q.push_back(CAUSE_MEI);
        exp_op_q.push_back(CAUSE_SSI);
        pulse(6'b110001);
        chk("tri_pend", {26'b0, intr_pend}, 6'b110001);
        serve();
        serve();
        serve();
        chk("tri_pend_done", {26'b0, intr_pend}, 0);

        // Masked by glb_ie: stays pending, dispatches once enabled.
        glb_ie = 1'b0;
        exp_op_q.push_back(CAUSE_SEI);
        pulse(6'b000100);
        tick();
        tick();
        tick();
        chk("seip_masked_vld", {31'b0, bus.intr_vld}, 0);
        chk("seip_masked_pend", {26'b0, intr_pend}, 6'b000100);
        glb_ie = 1'b1;
        tick();
        chk("seip_unmask_vld", {31'b0, bus.intr_vld}, 1);
        chk("seip_unmask_op", {28'b0, bus.intr_op}, 9);
        serve();

        // Debug ignores glb_ie.
        glb_ie = 1'b0;
        exp_op_q.push_back(CAUSE_DEBUG);
        pulse(6'b100000);
        tick();
        chk("dbg_noie_vld", {31'b0, bus.intr_vld}, 1);
        chk("dbg_noie_op", {28'b0, bus.intr_op}, 15);
        serve();
        glb_ie = 1'b1;

        // No preemption or retraction while in REQ.
        exp_op_q.push_back(CAUSE_SSI);
        exp_op_q.push_back(CAUSE_DEBUG);
        pulse(6'b000001);
        wait_vld();
        glb_ie  = 1'b0;
        intr_en = 5'b00000;
        pulse(6'b100000);
        chk("req_hold_vld", {31'b0, bus.intr_vld}, 1);
        chk("req_hold_op", {28'b0, bus.intr_op}, 1);
        chk("req_hold_pend", {26'b0, intr_pend}, 6'b100001);
        glb_ie  = 1'b1;
        intr_en = 5'b11111;
        serve();
        serve();

        // Re-pulse on the accept cycle keeps the bit set.
        exp_op_q.push_back(CAUSE_STI);
        exp_op_q.push_back(CAUSE_STI);
        pulse(6'b000010);
        wait_vld();
        chk("stip_op", {28'b0, bus.intr_op}, 5);
        bus.intr_rdy = 1'b1;
        drive_sync(6'b000010);
        tick();
        bus.intr_rdy = 1'b0;
        drive_sync(6'b0);
        chk("stip_repend", {26'b0, intr_pend}, 6'b000010);
        chk("stip_acc_vld", {31'b0, bus.intr_vld}, 0);
        bus.intr_clr = 1'b1;
        tick();
        bus.intr_clr = 1'b0;
        serve();

        // Watchdog expiry.
        exp_op_q.push_back(CAUSE_MSI);
        pulse(6'b001000);
        wait_vld();
        bus.intr_rdy = 1'b1;
        exp_err_cnt++;
        tick();
        bus.intr_rdy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("wd_quiet", {31'b0, intr_timeout_err}, 0);
            chk("wd_busy", {31'b0, intr_busy}, 1);
            tick();
        end
        chk("wd_fire", {31'b0, intr_timeout_err}, 1);
        tick();
        chk("wd_idle", {31'b0, intr_busy}, 0);
        chk("wd_err_once", {31'b0, intr_timeout_err}, 0);

        // intr_clr coinciding with expiry wins.
        exp_op_q.push_back(CAUSE_MSI);
        pulse(6'b001000);
        wait_vld();
        bus.intr_rdy = 1'b1;
        tick();
        bus.intr_rdy = 1'b0;
        tick();
        tick();
        tick();
        tick();
        bus.intr_clr = 1'b1;
        #1;
        chk("wd_clr_wins", {31'b0, intr_timeout_err}, 0);
        tick();
        bus.intr_clr = 1'b0;
        chk("wd_clr_idle", {31'b0, intr_busy}, 0);

        // Asynchronous reset while requesting.
        pulse(6'b001100);
        wait_vld();
        rst_n = 1'b0;
        #1;
        chk("arst_vld",  {31'b0, bus.intr_vld}, 0);
        chk("arst_op",   {28'b0, bus.intr_op}, 0);
        chk("arst_pend", {26'b0, intr_pend}, 0);
        chk("arst_busy", {31'b0, intr_busy}, 0);
        chk("arst_err",  {31'b0, intr_timeout_err}, 0);
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("post_rst_vld", {31'b0, bus.intr_vld}, 0);
        end
        chk("post_rst_pend", {26'b0, intr_pend}, 0);

        tick();
        chk("sb_drain", exp_op_q.size(), 0);
        chk("tmo_drain", exp_err_cnt, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
